nn_weight_loader: RTL and testbench

Streams signed fixed-point weights from a host-side valid/ready link and writes them into the weight memory that the hidden/output layer engine reads by address. It is the write side of the layer's weight-fetch interface: it produces the WE/address/data writes that the layer later reads back. It also verifies an end-of-frame checksum and holds the layer engine off (Busy) while the load is in progress.

---
 rtl/nn_pkg.sv | 21 ++
 rtl/nn_weight_loader.sv | 151 +++++++++++++++
 tb/tb_nn_weight_loader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the weight loader, the layer
// engine that reads the weight memory, and the loader bench.
package nn_pkg;

   // Weight format and memory geometry
   localparam int DATA_W    = 10;  // signed two's complement weight width
   localparam int ADDR_W    = 7;   // weight memory address width
   localparam int NUM_HID_W = 50;  // 10 inputs x 5 hidden neurons
   localparam int NUM_OUT_W = 15;  // 5 hidden x 3 output neurons
   localparam int OUT_BASE  = 64;  // first address of the output-layer block

   // Loader FSM encoding; the numeric values are visible on the debug port
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } loader_state_t;

endpackage

// File: rtl/nn_weight_loader.sv
// Weight loader: accepts a frame of signed weights over a valid/ready link,
// writes them into the weight memory (hidden block at 0.., output block at
// OUT_BASE..), then checks a trailing wrapping-sum checksum word.
//
// Handshake: a word transfers on a rising edge where in_valid & in_ready.
// in_ready depends only on the state (LOAD/CHECK), never on in_valid, and
// the host may hold in_valid low for any number of cycles.
module nn_weight_loader
   import nn_pkg::*;
#(
   parameter int P_DATA_W    = DATA_W,
   parameter int P_ADDR_W    = ADDR_W,
   parameter int P_NUM_HID_W = NUM_HID_W,
   parameter int P_NUM_OUT_W = NUM_OUT_W,
   parameter int P_OUT_BASE  = OUT_BASE
) (
   input  logic                  Clock,
   input  logic                  Rst,
   input  logic                  Start,
   input  logic                  in_valid,
   input  logic [P_DATA_W-1:0]   in_data,
   output logic                  in_ready,
   output logic                  WE,
   output logic [P_ADDR_W-1:0]   wr_addr,
   output logic [P_DATA_W-1:0]   wr_data,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Err,
   output logic [2:0]            state
);

   // Word counter must reach the index of the last weight
   localparam int NUM_W = P_NUM_HID_W + P_NUM_OUT_W;
   localparam int CNT_W = $clog2(NUM_W + 1);

   localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(NUM_W - 1);
   localparam logic [CNT_W-1:0]    HID_CNT  = CNT_W'(P_NUM_HID_W);
   localparam logic [P_ADDR_W-1:0] OUT_ADDR = P_ADDR_W'(P_OUT_BASE);

   loader_state_t         state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [P_DATA_W-1:0]   sum_q, sum_d;
   logic                  we_q, we_d;
   logic [P_ADDR_W-1:0]   addr_q, addr_d;
   logic [P_DATA_W-1:0]   data_q, data_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  ready;
   logic                  accept;
   logic [CNT_W-1:0]      out_idx;
   logic [P_ADDR_W-1:0]   map_addr;

   // Link is open only while a frame is in progress
   assign ready  = (state_q == ST_LOAD) || (state_q == ST_CHECK);
   assign accept = in_valid && ready;

   // Word index -> memory address: hidden block is contiguous from 0,
   // output block is relocated to OUT_BASE
   assign out_idx  = cnt_q - HID_CNT;
   assign map_addr = (cnt_q < HID_CNT) ? P_ADDR_W'(cnt_q)
                                       : OUT_ADDR + P_ADDR_W'(out_idx);

   // Next-state, counter, accumulator and write-port logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = done_q;
      err_d   = err_q;

      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (Start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               sum_d   = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end

         ST_LOAD: begin
            if (accept) begin
               we_d   = 1'b1;
               addr_d = map_addr;
               data_d = in_data;
               sum_d  = sum_q + in_data;  // wraps modulo 2^DATA_W
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  state_d = ST_CHECK;
               end
            end
         end

         ST_CHECK: begin
            // The checksum word is consumed but never written to memory
            if (accept) begin
               if (in_data == sum_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset does not touch memory contents,
   // Done=0 is what marks a partial load as invalid
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sum_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign in_ready = ready;
   assign Busy     = ready;
   assign WE       = we_q;
   assign wr_addr  = addr_q;
   assign wr_data  = data_q;
   assign Done     = done_q;
   assign Err      = err_q;
   assign state    = state_q;

endmodule

// File: tb/tb_nn_weight_loader.sv
// Directed bench for nn_weight_loader: frames of known weights, a write
// scoreboard against the reference address map, and status checks.
module tb_nn_weight_loader;

   localparam int DW = 10;
   localparam int AW = 7;
   localparam int NW = 65;

   logic          clk;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          we;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          done;
   logic          err;
   logic [2:0]    state;

   int n_cmp = 0;
   int n_err = 0;

   logic [AW+DW-1:0] exp_q[$];
   logic [AW+DW-1:0] got_q[$];

   nn_weight_loader dut (
      .Clock    (clk),
      .Rst      (rst),
      .Start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .WE       (we),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .Busy     (busy),
      .Done     (done),
      .Err      (err),
      .state    (state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write monitor: one entry per cycle with WE high
   always @(negedge clk) begin
      if (we === 1'b1) got_q.push_back({wr_addr, wr_data});
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] exp_addr(input int k);
      int a;
      a = (k < 50) ? k : 64 + (k - 50);
      return a[AW-1:0];
   endfunction

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_cycles(2);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("start_state", 32'(state), 32'd1);
      check_val("start_ready", 32'(in_ready), 32'd1);
      check_val("start_busy", 32'(busy), 32'd1);
      check_val("start_done_clr", 32'(done), 32'd0);
      check_val("start_err_clr", 32'(err), 32'd0);
   endtask

   // One word offered for one cycle; accepted on the next rising edge
   task automatic send_word(input logic [DW-1:0] d, input bit stall);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      if (stall) @(negedge clk);
   endtask

   task automatic compare_writes(input string tag);
      int n;
      n = exp_q.size();
      check_val({tag, "_wr_count"}, 32'(got_q.size()), 32'(n));
      for (int i = 0; i < n && got_q.size() > 0; i++) begin
         logic [AW+DW-1:0] g, e;
         g = got_q.pop_front();
         e = exp_q.pop_front();
         if (g !== e) check_val({tag, "_wr"}, 32'(g), 32'(e));
         else n_cmp++;
      end
      exp_q.delete();
      got_q.delete();
   endtask

   // Full frame: 65 weights of value w, then checksum cs; optional
   // Start pulse alongside word start_at
   task automatic run_frame(input string tag, input logic [DW-1:0] w,
                            input logic [DW-1:0] cs, input bit stall,
                            input int start_at);
      got_q.delete();
      exp_q.delete();
      pulse_start();
      for (int k = 0; k < NW; k++) begin
         exp_q.push_back({exp_addr(k), w});
         if (k == start_at) start = 1'b1;
         send_word(w, stall);
         start = 1'b0;
         if (k == start_at) check_val({tag, "_ign_start_state"}, 32'(state), 32'd1);
         if (k == NW - 1) check_val({tag, "_check_state"}, 32'(state), 32'd2);
      end
      send_word(cs, 1'b0);
      idle_cycles(2);
      compare_writes(tag);
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;

      // Reset values
      do_reset();
      check_val("rst_state", 32'(state), 32'd0);
      check_val("rst_ready", 32'(in_ready), 32'd0);
      check_val("rst_we", 32'(we), 32'd0);
      check_val("rst_addr", 32'(wr_addr), 32'd0);
      check_val("rst_data", 32'(wr_data), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);

      // Nominal: 65 x 1, checksum 65
      run_frame("nom", 10'h001, 10'd65, 1'b0, -1);
      check_val("nom_done", 32'(done), 32'd1);
      check_val("nom_err", 32'(err), 32'd0);
      check_val("nom_busy", 32'(busy), 32'd0);
      check_val("nom_ready", 32'(in_ready), 32'd0);
      check_val("nom_state", 32'(state), 32'd3);

      // Wrap: 65 x -1 sums to -65 = 10'h3BF
      run_frame("wrap", 10'h3FF, 10'h3BF, 1'b0, -1);
      check_val("wrap_done", 32'(done), 32'd1);
      check_val("wrap_err", 32'(err), 32'd0);

      // Same weights, wrong checksum
      run_frame("bad", 10'h3FF, 10'h000, 1'b0, -1);
      check_val("bad_done", 32'(done), 32'd0);
      check_val("bad_err", 32'(err), 32'd1);
      check_val("bad_state", 32'(state), 32'd4);
      check_val("bad_busy", 32'(busy), 32'd0);

      // Stall: in_valid alternates 1/0, mixed data value
      run_frame("stall", 10'h155, 10'(65 * 10'h155), 1'b1, -1);
      check_val("stall_done", 32'(done), 32'd1);
      check_val("stall_err", 32'(err), 32'd0);

      // Ignored Start at word 20
      run_frame("ign", 10'h002, 10'd130, 1'b0, 20);
      check_val("ign_done", 32'(done), 32'd1);

      // Abort after 30 words
      got_q.delete();
      exp_q.delete();
      pulse_start();
      for (int k = 0; k < 30; k++) begin
         exp_q.push_back({exp_addr(k), 10'h07});
         send_word(10'h07, 1'b0);
      end
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b1;
      in_data  = 10'h07;
      idle_cycles(1);
      check_val("abort_state", 32'(state), 32'd0);
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_ready", 32'(in_ready), 32'd0);
      check_val("abort_done", 32'(done), 32'd0);
      rst = 1'b0;
      idle_cycles(8);
      in_valid = 1'b0;
      compare_writes("abort");

      run_frame("reload", 10'h3F0, 10'(65 * 10'h3F0), 1'b0, -1);
      check_val("reload_done", 32'(done), 32'd1);
      check_val("reload_err", 32'(err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
